pb_press_classifier: RTL and testbench

PB_PRESS_CLASSIFIER -- requirements
Module: pb_press_classifier

---
 rtl/pb_pkg.sv | 32 +++
 rtl/pb_event_timer.sv | 47 ++++
 rtl/pb_press_classifier.sv | 174 +++++++++++++++++
 tb/tb_pb_press_classifier.sv | 268 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/pb_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : pb_pkg
//  Description : Shared definitions for the push-button press classifier:
//                state encodings, default timing constants and a helper
//                for sizing the shared event counter.
//                Optional feature macro: PB_DOUBLE_CLICK_EN (see classifier).
//  Revision    : 1.0 - initial release
// ============================================================================
package pb_pkg;

    // Default thresholds at a 25 MHz clock: 0.5 s long press, 0.3 s gap.
    localparam int PB_LONG_CYCLES_DEF = 12_500_000;
    localparam int PB_DBL_CYCLES_DEF  = 7_500_000;

    // Classifier state encoding (explicit 3-bit width).
    typedef enum logic [2:0] {
        ST_IDLE           = 3'd0,
        ST_PRESSED        = 3'd1,
        ST_LONG_HELD      = 3'd2,
        ST_WAIT_SECOND    = 3'd3,
        ST_SECOND_PRESSED = 3'd4
    } pb_state_e;

    // Counter width: wide enough for the larger threshold plus one spare
    // bit, so the saturating counter never reaches a wrap condition.
    function automatic int pb_cnt_width(input int a, input int b);
        return $clog2((a > b) ? a : b) + 1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/pb_event_timer.sv
`default_nettype none
// ============================================================================
//  Module      : pb_event_timer
//  Description : Saturating cycle counter shared by the classifier states.
//                Synchronous clear (priority) and enable, plus an equality
//                compare against a caller-supplied terminal value.
//  Revision    : 1.0 - initial release
// ============================================================================
module pb_event_timer #(
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_clear,
    input  logic             i_enable,
    input  logic [CNT_W-1:0] i_term,
    output logic             o_at_term
);

    localparam logic [CNT_W-1:0] c_cnt_max = {CNT_W{1'b1}};

    logic [CNT_W-1:0] r_cnt_q;
    logic [CNT_W-1:0] w_cnt_d;

    // Next count: clear wins, otherwise count up and hold at all-ones.
    always_comb begin
        w_cnt_d = r_cnt_q;
        if (i_clear) begin
            w_cnt_d = '0;
        end else if (i_enable && (r_cnt_q != c_cnt_max)) begin
            w_cnt_d = r_cnt_q + 1'b1;
        end
    end

    // Counter register with asynchronous reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cnt_q <= '0;
        end else begin
            r_cnt_q <= w_cnt_d;
        end
    end

    assign o_at_term = (r_cnt_q == i_term);

endmodule
`default_nettype wire

// File: rtl/pb_press_classifier.sv
`default_nettype none
// ============================================================================
//  Module      : pb_press_classifier
//  Description : Classifies debounced button press/release pulses into
//                short press, long press (with hold level) and, when the
//                PB_DOUBLE_CLICK_EN macro is defined, double click.
//                Without PB_DOUBLE_CLICK_EN a short release reports
//                short_press at once and double_click is tied low.
//  Revision    : 1.0 - initial release
// ============================================================================
module pb_press_classifier
    import pb_pkg::*;
#(
    parameter int LONG_CYCLES = PB_LONG_CYCLES_DEF,
    parameter int DBL_CYCLES  = PB_DBL_CYCLES_DEF
) (
    input  logic clk,
    input  logic rst,
    input  logic PB_down,
    input  logic PB_up,
    output logic short_press,
    output logic long_press,
    output logic double_click,
    output logic hold,
    output logic busy
);

    localparam int CNT_W = pb_cnt_width(LONG_CYCLES, DBL_CYCLES);
    localparam logic [CNT_W-1:0] c_long_term = CNT_W'(LONG_CYCLES - 1);
    localparam logic [CNT_W-1:0] c_dbl_term  = CNT_W'(DBL_CYCLES - 1);

    pb_state_e        r_state_q;
    pb_state_e        w_state_d;
    logic             r_short_q, w_short_d;
    logic             r_long_q,  w_long_d;
    logic             r_hold_q,  w_hold_d;
    logic             r_busy_q,  w_busy_d;
    logic             w_down;
    logic             w_up;
    logic             w_clear;
    logic             w_enable;
    logic             w_at_term;
    logic [CNT_W-1:0] w_term;

    // Simultaneous press and release pulses cancel to no event.
    assign w_down = PB_down & ~PB_up;
    assign w_up   = PB_up   & ~PB_down;

    // Counter restarts on every state change and runs in the timed states;
    // the gap window uses its own threshold, all others the long threshold.
    assign w_clear  = (w_state_d != r_state_q);
    assign w_enable = (r_state_q == ST_PRESSED) || (r_state_q == ST_WAIT_SECOND) ||
                      (r_state_q == ST_SECOND_PRESSED);
    assign w_term   = (r_state_q == ST_WAIT_SECOND) ? c_dbl_term : c_long_term;

    pb_event_timer #(
        .CNT_W (CNT_W)
    ) u_timer (
        .clk       (clk),
        .rst       (rst),
        .i_clear   (w_clear),
        .i_enable  (w_enable),
        .i_term    (w_term),
        .o_at_term (w_at_term)
    );

`ifdef PB_DOUBLE_CLICK_EN
    logic r_dbl_q, w_dbl_d;
`endif

    // Next-state and registered-output inputs; a release exactly at the
    // long threshold counts as the end of a long hold, so it is silent.
    always_comb begin
        w_state_d = r_state_q;
        w_short_d = 1'b0;
        w_long_d  = 1'b0;
`ifdef PB_DOUBLE_CLICK_EN
        w_dbl_d   = 1'b0;
`endif
        case (r_state_q)
            ST_IDLE: begin
                if (w_down) begin
                    w_state_d = ST_PRESSED;
                end
            end
            ST_PRESSED: begin
                if (w_up) begin
                    if (!w_at_term) begin
`ifdef PB_DOUBLE_CLICK_EN
                        w_state_d = ST_WAIT_SECOND;
`else
                        w_short_d = 1'b1;
                        w_state_d = ST_IDLE;
`endif
                    end else begin
                        w_state_d = ST_IDLE;
                    end
                end else if (w_at_term) begin
                    w_long_d  = 1'b1;
                    w_state_d = ST_LONG_HELD;
                end
            end
            ST_LONG_HELD: begin
                if (w_up) begin
                    w_state_d = ST_IDLE;
                end
            end
`ifdef PB_DOUBLE_CLICK_EN
            ST_WAIT_SECOND: begin
                if (w_at_term) begin
                    w_short_d = 1'b1;
                    w_state_d = ST_IDLE;
                end else if (w_down) begin
                    w_state_d = ST_SECOND_PRESSED;
                end
            end
            ST_SECOND_PRESSED: begin
                if (w_up) begin
                    if (!w_at_term) begin
                        w_dbl_d = 1'b1;
                    end
                    w_state_d = ST_IDLE;
                end else if (w_at_term) begin
                    w_long_d  = 1'b1;
                    w_state_d = ST_LONG_HELD;
                end
            end
`endif
            default: begin
                w_state_d = ST_IDLE;
            end
        endcase
        w_hold_d = (w_state_d == ST_LONG_HELD);
        w_busy_d = (w_state_d != ST_IDLE);
    end

    // State and output registers; reset forces IDLE and silent outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state_q <= ST_IDLE;
            r_short_q <= 1'b0;
            r_long_q  <= 1'b0;
            r_hold_q  <= 1'b0;
            r_busy_q  <= 1'b0;
        end else begin
            r_state_q <= w_state_d;
            r_short_q <= w_short_d;
            r_long_q  <= w_long_d;
            r_hold_q  <= w_hold_d;
            r_busy_q  <= w_busy_d;
        end
    end

`ifdef PB_DOUBLE_CLICK_EN
    // Double-click pulse register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_dbl_q <= 1'b0;
        end else begin
            r_dbl_q <= w_dbl_d;
        end
    end
    assign double_click = r_dbl_q;
`else
    assign double_click = 1'b0;
`endif

    assign short_press = r_short_q;
    assign long_press  = r_long_q;
    assign hold        = r_hold_q;
    assign busy        = r_busy_q;

endmodule
`default_nettype wire

// File: tb/tb_pb_press_classifier.sv
`default_nettype none
// ============================================================================
//  Module      : tb_pb_press_classifier
//  Description : Directed self-checking bench for pb_press_classifier with
//                LONG_CYCLES=16, DBL_CYCLES=8. Expectations follow the
//                PB_DOUBLE_CLICK_EN setting of the build.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_pb_press_classifier;

    logic clk = 1'b0;
    logic rst;
    logic PB_down;
    logic PB_up;
    logic short_press;
    logic long_press;
    logic double_click;
    logic hold;
    logic busy;

    int total = 0;
    int bad   = 0;
    int n_short = 0;
    int n_long  = 0;
    int n_dbl   = 0;

    pb_press_classifier #(
        .LONG_CYCLES (16),
        .DBL_CYCLES  (8)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .PB_down      (PB_down),
        .PB_up        (PB_up),
        .short_press  (short_press),
        .long_press   (long_press),
        .double_click (double_click),
        .hold         (hold),
        .busy         (busy)
    );

    always #5 clk = ~clk;

    task automatic chk1(input string tag, input logic obs, input logic exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    task automatic chkn(input string tag, input int obs, input int exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // One clock, sampled 1 ns after the edge; tallies pulses and checks
    // that at most one classification pulse is high.
    task automatic tick();
        logic excl;
        @(posedge clk);
        #1;
        n_short += int'(short_press);
        n_long  += int'(long_press);
        n_dbl   += int'(double_click);
        excl = ((int'(short_press) + int'(long_press) + int'(double_click)) <= 1);
        chk1("one_pulse", excl, 1'b1);
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic clr_counts();
        n_short = 0;
        n_long  = 0;
        n_dbl   = 0;
    endtask

    task automatic pulse_down();
        PB_down = 1'b1;
        tick();
        PB_down = 1'b0;
    endtask

    task automatic pulse_up();
        PB_up = 1'b1;
        tick();
        PB_up = 1'b0;
    endtask

    initial begin
        rst     = 1'b1;
        PB_down = 1'b0;
        PB_up   = 1'b0;

        // Reset state
        run(2);
        chk1("rst_short", short_press, 1'b0);
        chk1("rst_long",  long_press,  1'b0);
        chk1("rst_dbl",   double_click, 1'b0);
        chk1("rst_hold",  hold, 1'b0);
        chk1("rst_busy",  busy, 1'b0);

        // Press honoured on the first edge with reset low
        rst     = 1'b0;
        PB_down = 1'b1;
        tick();
        PB_down = 1'b0;
        chk1("first_press_busy", busy, 1'b1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        tick();
        chk1("rerst_busy", busy, 1'b0);

        // Ignored events in IDLE: stray release, simultaneous down+up
        pulse_up();
        chk1("idle_up_ignored", busy, 1'b0);
        PB_down = 1'b1;
        PB_up   = 1'b1;
        tick();
        PB_down = 1'b0;
        PB_up   = 1'b0;
        chk1("both_no_event", busy, 1'b0);

        // Short press of 5 cycles
        clr_counts();
        pulse_down();
        run(4);
        pulse_up();
`ifdef PB_DOUBLE_CLICK_EN
        chk1("short_at_up", short_press, 1'b0);
        chk1("short_wait_busy", busy, 1'b1);
        run(7);
        chkn("short_early", n_short, 0);
        tick();
        chk1("short_at_gap", short_press, 1'b1);
        tick();
        chk1("short_after", short_press, 1'b0);
`else
        chk1("short_at_up", short_press, 1'b1);
        tick();
        chk1("short_after", short_press, 1'b0);
`endif
        chk1("short_idle_busy", busy, 1'b0);
        run(10);
        chkn("short_count", n_short, 1);
        chkn("short_no_long", n_long, 0);

        // Long hold of 20 cycles
        clr_counts();
        pulse_down();
        run(15);
        chk1("long_early", long_press, 1'b0);
        chk1("hold_early", hold, 1'b0);
        tick();
        chk1("long_at_16", long_press, 1'b1);
        chk1("hold_at_16", hold, 1'b1);
        tick();
        chk1("long_after", long_press, 1'b0);
        chk1("hold_kept", hold, 1'b1);
        run(2);
        pulse_up();
        chk1("hold_released", hold, 1'b0);
        chk1("long_idle_busy", busy, 1'b0);
        run(10);
        chkn("long_count", n_long, 1);
        chkn("long_no_short", n_short, 0);

`ifdef PB_DOUBLE_CLICK_EN
        // Double click: press 3, release 4, press 3
        clr_counts();
        pulse_down();
        run(2);
        pulse_up();
        run(3);
        pulse_down();
        chk1("dbl_second_busy", busy, 1'b1);
        run(2);
        pulse_up();
        chk1("dbl_pulse", double_click, 1'b1);
        chk1("dbl_idle_busy", busy, 1'b0);
        run(10);
        chkn("dbl_count", n_dbl, 1);
        chkn("dbl_no_short", n_short, 0);

        // Press 3, release 4, long second press
        clr_counts();
        pulse_down();
        run(2);
        pulse_up();
        run(3);
        pulse_down();
        run(15);
        chk1("sec_long_early", long_press, 1'b0);
        tick();
        chk1("sec_long_pulse", long_press, 1'b1);
        chk1("sec_long_hold", hold, 1'b1);
        run(2);
        pulse_up();
        run(10);
        chkn("sec_long_count", n_long, 1);
        chkn("sec_long_no_dbl", n_dbl, 0);
        chkn("sec_long_no_short", n_short, 0);

        // Second press arriving exactly as the gap window closes
        clr_counts();
        pulse_down();
        run(2);
        pulse_up();
        run(7);
        PB_down = 1'b1;
        tick();
        PB_down = 1'b0;
        chk1("gap_edge_short", short_press, 1'b1);
        chk1("gap_edge_idle", busy, 1'b0);
        run(5);
        chkn("gap_edge_no_dbl", n_dbl, 0);
`else
        // Two short presses 2 cycles apart: two short_press, no double_click
        clr_counts();
        pulse_down();
        run(2);
        pulse_up();
        chk1("s1_pulse", short_press, 1'b1);
        tick();
        pulse_down();
        run(2);
        pulse_up();
        chk1("s2_pulse", short_press, 1'b1);
        run(5);
        chkn("two_short_count", n_short, 2);
        chkn("two_short_no_dbl", n_dbl, 0);
        chk1("dbl_tied_low", double_click, 1'b0);
`endif

        // Asynchronous reset mid-press at cnt=10
        clr_counts();
        pulse_down();
        run(10);
        chk1("mid_busy", busy, 1'b1);
        #2;
        rst = 1'b1;
        #1;
        chk1("arst_busy",  busy, 1'b0);
        chk1("arst_hold",  hold, 1'b0);
        chk1("arst_short", short_press, 1'b0);
        chk1("arst_long",  long_press, 1'b0);
        tick();
        rst = 1'b0;
        tick();
        pulse_up();
        run(20);
        chkn("arst_no_short", n_short, 0);
        chkn("arst_no_long",  n_long, 0);
        chkn("arst_no_dbl",   n_dbl, 0);
        chk1("arst_end_busy", busy, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
